xbus_arbiter: RTL and testbench
===============================

# xbus_arbiter

Two-master arbiter and transfer sequencer for the xbus. It shares the single xbus between the CPU data port (M0) and a secondary master (M1, debug/DMA), using round-robin arbitration. It drives the bus address strobe and latched transfer fields, and waits for slave acknowledge. Decode misses and unacknowledged transfers terminate with an error instead of hanging the bus. It sits between the masters and the xbus address decoder / slave mux.

## Interface
- TIMEOUT, 16: maximum XFER cycles without `xbus_ack` before error termination. Must be ≥1.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req / m1_req  in  1  transfer request. Held high until the matching done.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  32  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_done / m1_done  out  1  one-cycle completion pulse.
- m0_err / m1_err  out  1  error flag. Valid only while the matching done is high.
- m_rdata  out  32  read data, shared by both masters. Valid while either done is high.
- xbus_as  out  1  address strobe.
- xbus_addr  out  32  latched address.
- xbus_we  out  1  latched write enable.
- xbus_wdata  out  32  latched write data.
- xbus_rdata  in  32  slave read data.
- xbus_ack  in  1  slave acknowledge. Single cycle, sampled only in XFER.
- xbus_hit  in  1  OR of the decoder chip-selects. Valid while `xbus_as` = 1.

## Operation
- FSM states: IDLE, XFER, RESP.
- IDLE
  - No request: stay in IDLE.
  - Exactly one requester: grant it.
  - Both requesting: grant the master that is not `last`.
  - On grant: latch that master's addr, we and wdata into the xbus registers; set `last` to the granted id; clear `cnt`; go to XFER.
- XFER
  - `xbus_as` = 1; `cnt` increments every cycle.
  - Priority 1: `xbus_ack` = 1 → capture `xbus_rdata` into `m_rdata`, err = 0, go to RESP.
  - Priority 2: `xbus_hit` = 0 → err = 1, `m_rdata` = 0, go to RESP. Ack wins over a miss in the same cycle.
  - Priority 3: `cnt` == TIMEOUT-1 → err = 1, `m_rdata` = 0, go to RESP.
  - Otherwise stay in XFER.
- RESP
  - Granted master's done = 1 and err = the captured value; the other master's done = 0.
  - `xbus_as` = 0; requests are ignored.
  - Unconditionally go to IDLE.
- Request rules:
  - A master that wants no further transfer must have req low by the IDLE cycle after RESP.
  - If req is still high in that cycle, it is a new request.
  - req/addr/we/wdata changes during XFER have no effect, because fields are latched at grant.
- Width: `cnt` is `$clog2(TIMEOUT+1)` bits and never wraps; it is cleared at grant.
- Writes: `xbus_rdata` is still captured on ack; masters ignore `m_rdata` for writes.

## Timing
- Reset values:
  - state = IDLE, `last` = 1 (so M0 wins the first contention).
  - `xbus_as` = 0; `xbus_addr`, `xbus_we`, `xbus_wdata` = 0.
  - `m_rdata` = 0; all done/err = 0; `cnt` = 0.
- Reset mid-transfer: all of the above take effect immediately (asynchronous), with no done pulse. The aborted master must re-request.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- Minimum latency, with ack in the first XFER cycle:
  - cycle 0: IDLE samples req.
  - cycle 1: XFER, `xbus_as` = 1, ack sampled.
  - cycle 2: RESP, done = 1.
  - cycle 3: IDLE, next grant possible.
- Throughput: one transfer per 3 cycles minimum; a wait state adds 1 cycle each.
- Timeout: with no ack or miss, `xbus_as` stays high for exactly TIMEOUT cycles, then RESP with err = 1. Ack in the TIMEOUT-th cycle completes normally.
- Fairness: under continuous requests from both masters, grants strictly alternate M0, M1, M0, ….

## Test plan
- Reset, then M0 read of 0x00001000 with ack in the first XFER cycle and `xbus_rdata` = 0x12345678 → `xbus_as` high for 1 cycle; `m0_done` = 1 and `m0_err` = 0 on cycle 2; `m_rdata` = 0x12345678; `m1_done` never asserted.
- m0_req and m1_req rise in the same cycle after reset, both held for 4 transfers, 1 ack-wait cycle each → grant order M0, M1, M0, M1; each transfer is exactly 4 cycles from grant to the next IDLE.
- M1 write to 0x80000010, data 0xCAFEF00D, ack after 3 wait cycles → `xbus_addr`/`xbus_we`/`xbus_wdata` stable for all 4 XFER cycles, even when `m1_addr` is changed mid-transfer; `m1_done` = 1 with err = 0.
- M0 access to 0x00020000 with `xbus_hit` = 0 → exactly 1 XFER cycle, then `m0_done` = 1, `m0_err` = 1, `m_rdata` = 0.
- TIMEOUT = 16, `xbus_hit` = 1, no ack → `xbus_as` high for exactly 16 cycles, then done with err = 1. Repeat with ack in cycle 16 → err = 0.
- `rst` asserted in the 2nd XFER cycle of an M1 transfer → `xbus_as` drops asynchronously, no done pulse; after release, a pending M0 request is granted first (`last` = 1).

Source files
------------

// File: rtl/xbus_arbiter_if.sv
// xbus_arbiter_if: bundles the two master request ports, the shared
// read-data return and the xbus transfer signals.
//
// Handshake: a master raises mN_req with stable mN_we/mN_addr/mN_wdata and
// holds it until mN_done pulses for one cycle. mN_err and m_rdata are only
// meaningful in that done cycle. On the xbus side, xbus_as marks a live
// transfer. The slave answers with a one-cycle xbus_ack. xbus_hit reports the
// decoder hit while xbus_as is high.
interface xbus_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_done;
    logic        m0_err;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_done;
    logic        m1_err;
    logic [31:0] m_rdata;
    logic        xbus_as;
    logic [31:0] xbus_addr;
    logic        xbus_we;
    logic [31:0] xbus_wdata;
    logic [31:0] xbus_rdata;
    logic        xbus_ack;
    logic        xbus_hit;

    // Requesting masters plus the addressed slave side.
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m0_done, m0_err, m1_done, m1_err, m_rdata,
        input  xbus_as, xbus_addr, xbus_we, xbus_wdata,
        output xbus_rdata, xbus_ack, xbus_hit
    );

    // The arbiter itself.
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m0_done, m0_err, m1_done, m1_err, m_rdata,
        output xbus_as, xbus_addr, xbus_we, xbus_wdata,
        input  xbus_rdata, xbus_ack, xbus_hit
    );
endinterface

// File: rtl/xbus_arbiter.sv
// xbus_arbiter: round-robin arbiter between two masters plus the xbus
// transfer sequencer. A granted transfer runs IDLE -> XFER (one or more
// cycles) -> RESP. It ends on ack, on a decode miss, or on timeout. Every
// output is a register or a decode of registered state.
module xbus_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    xbus_arbiter_if.slave bus,
    output logic [1:0]    state_dbg
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             last;       // id of the most recently granted master
    logic             grant_sel;  // id to grant if IDLE sees a request
    logic             any_req;
    logic             timeout_hit;
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic [31:0]      addr_q;
    logic             we_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the round-robin grant choice.
    always_comb begin
        next_state  = state;
        any_req     = bus.m0_req | bus.m1_req;
        grant_sel   = (bus.m0_req && bus.m1_req) ? ~last : bus.m1_req;
        timeout_hit = (cnt == CNT_LAST);
        case (state)
            IDLE: begin
                if (any_req) next_state = XFER;
            end
            XFER: begin
                if (bus.xbus_ack || !bus.xbus_hit || timeout_hit) next_state = RESP;
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Grant bookkeeping, latched transfer fields, wait counter and response capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last    <= 1'b1;
            cnt     <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        last    <= grant_sel;
                        cnt     <= '0;
                        addr_q  <= grant_sel ? bus.m1_addr  : bus.m0_addr;
                        we_q    <= grant_sel ? bus.m1_we    : bus.m0_we;
                        wdata_q <= grant_sel ? bus.m1_wdata : bus.m0_wdata;
                    end
                end
                XFER: begin
                    // cnt stops short of wrapping because XFER exits at TIMEOUT-1.
                    cnt <= cnt + CNT_W'(1);
                    if (bus.xbus_ack) begin
                        rdata_q <= bus.xbus_rdata;
                        err_q   <= 1'b0;
                    end else if (!bus.xbus_hit || timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: registered fields plus decodes of state and the grant id.
    assign bus.xbus_as    = (state == XFER);
    assign bus.xbus_addr  = addr_q;
    assign bus.xbus_we    = we_q;
    assign bus.xbus_wdata = wdata_q;
    assign bus.m_rdata    = rdata_q;
    assign bus.m0_done    = (state == RESP) && !last;
    assign bus.m1_done    = (state == RESP) && last;
    assign bus.m0_err     = (state == RESP) && !last && err_q;
    assign bus.m1_err     = (state == RESP) && last && err_q;
    assign state_dbg      = state;

endmodule

// File: tb/tb_xbus_arbiter.sv
// tb_xbus_arbiter: randomized and directed transfers checked against a
// transaction-level model. The model tracks the last grant and the work
// pending per master. Transfer length and error come from the earliest of
// ack, miss and timeout.
module tb_xbus_arbiter;

    localparam int TIMEOUT = 16;

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;

    xbus_arbiter_if bus ();

    xbus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int          pend0;
    int          pend1;
    int          model_last;
    logic        fixed;
    logic [31:0] fix_addr;
    logic        fix_we;
    logic [31:0] fix_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_reset_values();
        check("rst_as",     {31'd0, bus.xbus_as}, 32'd0);
        check("rst_addr",   bus.xbus_addr, 32'd0);
        check("rst_we",     {31'd0, bus.xbus_we}, 32'd0);
        check("rst_wdata",  bus.xbus_wdata, 32'd0);
        check("rst_rdata",  bus.m_rdata, 32'd0);
        check("rst_done",   {30'd0, bus.m1_done, bus.m0_done}, 32'd0);
        check("rst_err",    {30'd0, bus.m1_err, bus.m0_err}, 32'd0);
    endtask

    // driver: full reset, leaves the bench at an IDLE negedge
    task automatic do_reset();
        rst = 1'b1;
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.xbus_rdata = '0; bus.xbus_ack = 1'b0; bus.xbus_hit = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        model_last = 1;
    endtask

    // driver + model for one transfer. Entered at an IDLE negedge with
    // pend0/pend1 describing which masters want work; returns at the next
    // IDLE negedge.
    task automatic do_xfer(input int ack_at, input int miss_at, input logic [31:0] rd);
        int          g;
        int          len;
        logic        err_exp;
        logic [31:0] ea;
        logic [31:0] ewd;
        logic        ewe;
        bus.m0_req = (pend0 > 0);
        bus.m1_req = (pend1 > 0);
        if (fixed) begin
            bus.m0_addr = fix_addr; bus.m0_we = fix_we; bus.m0_wdata = fix_wdata;
            bus.m1_addr = fix_addr; bus.m1_we = fix_we; bus.m1_wdata = fix_wdata;
        end else begin
            bus.m0_addr  = $urandom() & 32'h7fff_ffff;
            bus.m1_addr  = $urandom() | 32'h8000_0000;
            bus.m0_we    = 1'($urandom_range(0, 1));
            bus.m1_we    = 1'($urandom_range(0, 1));
            bus.m0_wdata = $urandom();
            bus.m1_wdata = $urandom();
        end
        if (pend0 > 0 && pend1 > 0) g = (model_last == 1) ? 0 : 1;
        else g = (pend1 > 0) ? 1 : 0;
        ea  = (g == 1) ? bus.m1_addr  : bus.m0_addr;
        ewe = (g == 1) ? bus.m1_we    : bus.m0_we;
        ewd = (g == 1) ? bus.m1_wdata : bus.m0_wdata;
        len = TIMEOUT;
        if (ack_at > 0 && ack_at < len) len = ack_at;
        if (miss_at > 0 && miss_at < len) len = miss_at;
        err_exp = (ack_at != len);

        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            check("xfer_as",    {31'd0, bus.xbus_as}, 32'd1);
            check("xfer_addr",  bus.xbus_addr, ea);
            check("xfer_we",    {31'd0, bus.xbus_we}, {31'd0, ewe});
            check("xfer_wdata", bus.xbus_wdata, ewd);
            check("xfer_done",  {30'd0, bus.m1_done, bus.m0_done}, 32'd0);
            bus.xbus_ack   = (k == ack_at);
            bus.xbus_hit   = (k != miss_at);
            bus.xbus_rdata = rd;
            if (k == 2) begin
                bus.m0_addr = $urandom(); bus.m0_wdata = $urandom(); bus.m0_we = ~bus.m0_we;
                bus.m1_addr = $urandom(); bus.m1_wdata = $urandom(); bus.m1_we = ~bus.m1_we;
            end
        end

        @(negedge clk);
        bus.xbus_ack = 1'b0;
        bus.xbus_hit = 1'b1;
        check("resp_as",    {31'd0, bus.xbus_as}, 32'd0);
        check("resp_done",  {30'd0, bus.m1_done, bus.m0_done}, (g == 1) ? 32'd2 : 32'd1);
        check("resp_err",   {30'd0, bus.m1_err, bus.m0_err},
              err_exp ? ((g == 1) ? 32'd2 : 32'd1) : 32'd0);
        check("resp_rdata", bus.m_rdata, err_exp ? 32'd0 : rd);

        model_last = g;
        if (g == 1) pend1--; else pend0--;
        bus.m0_req = (pend0 > 0);
        bus.m1_req = (pend1 > 0);

        @(negedge clk);
        check("idle_as",   {31'd0, bus.xbus_as}, 32'd0);
        check("idle_done", {30'd0, bus.m1_done, bus.m0_done}, 32'd0);
    endtask

    initial begin
        fixed = 1'b0;
        fix_addr = '0; fix_we = 1'b0; fix_wdata = '0;
        pend0 = 0; pend1 = 0;
        do_reset();

        // M0 read, ack in first XFER cycle
        fixed = 1'b1; fix_addr = 32'h0000_1000; fix_we = 1'b0; fix_wdata = 32'h0;
        pend0 = 1; pend1 = 0;
        do_xfer(1, 0, 32'h1234_5678);

        // simultaneous requests, 2 each, one wait state: M0, M1, M0, M1
        fixed = 1'b0;
        pend0 = 2; pend1 = 2;
        while (pend0 + pend1 > 0) do_xfer(2, 0, $urandom());

        // M1 write with 3 wait cycles, fields changed mid-transfer
        fixed = 1'b1; fix_addr = 32'h8000_0010; fix_we = 1'b1; fix_wdata = 32'hCAFE_F00D;
        pend0 = 0; pend1 = 1;
        do_xfer(4, 0, 32'h5555_AAAA);

        // decode miss in first cycle
        fix_addr = 32'h0002_0000; fix_we = 1'b0; fix_wdata = 32'h0;
        pend0 = 1; pend1 = 0;
        do_xfer(0, 1, 32'hDEAD_BEEF);

        // timeout, then ack in the last allowed cycle
        fixed = 1'b0;
        pend0 = 1; pend1 = 0;
        do_xfer(0, 0, 32'h0BAD_0BAD);
        pend0 = 0; pend1 = 1;
        do_xfer(TIMEOUT, 0, 32'h600D_600D);

        // reset in the 2nd XFER cycle of an M1 transfer
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b1;
        bus.m1_addr = 32'h8000_0100;
        @(negedge clk);
        check("rst_mid_as1", {31'd0, bus.xbus_as}, 32'd1);
        @(negedge clk);
        check("rst_mid_as2", {31'd0, bus.xbus_as}, 32'd1);
        bus.m0_req = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_async_as",   {31'd0, bus.xbus_as}, 32'd0);
        check("rst_async_done", {30'd0, bus.m1_done, bus.m0_done}, 32'd0);
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        model_last = 1;
        pend0 = 1; pend1 = 1;
        while (pend0 + pend1 > 0) do_xfer(1, 0, $urandom());

        // randomized sessions
        for (int it = 0; it < 20; it++) begin
            pend0 = $urandom_range(0, 3);
            pend1 = $urandom_range(0, 3);
            while (pend0 + pend1 > 0) begin
                int a;
                int m;
                a = $urandom_range(0, TIMEOUT + 2);
                m = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TIMEOUT) : 0;
                do_xfer(a, m, $urandom());
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
